pc_stack: RTL

- Program counter and hardware return stack for the PIC16C5x core.
- Sits directly upstream of program memory and the instruction register: drives the program-memory fetch address whose data the IR latches at FE_Q4.
- Takes branch, call and return controls from the execute stage.
- Implements PIC16C5x paging rules (PA bits), computed-goto via PCL writes, and a fixed-depth LIFO return stack.

---
 rtl/pc_stack_pkg.sv | 28 ++
 rtl/pc_stack_if.sv | 36 +++
 rtl/pc_stack_return_stack.sv | 43 ++++
 rtl/pc_stack.sv | 74 +++++++
 4 files changed

// File: rtl/pc_stack_pkg.sv
// Shared PIC16C5x core definitions: Q-phase encodings, file addresses and
// default PC/return-stack geometry.
package pc_stack_pkg;

  localparam int unsigned FE_STATE_BITS = 2;
  localparam int unsigned EX_STATE_BITS = 2;

  typedef enum logic [FE_STATE_BITS-1:0] {
    FE_Q1 = 2'd0,
    FE_Q2 = 2'd1,
    FE_Q3 = 2'd2,
    FE_Q4 = 2'd3
  } fe_state_t;

  typedef enum logic [EX_STATE_BITS-1:0] {
    EX_Q1 = 2'd0,
    EX_Q2 = 2'd1,
    EX_Q3 = 2'd2,
    EX_Q4 = 2'd3
  } ex_state_t;

  localparam logic [7:0] PCL_ADDR = 8'h02;

  localparam int unsigned PC_WIDTH_DEFAULT    = 11;
  localparam int unsigned STACK_DEPTH_DEFAULT = 2;
  localparam logic [PC_WIDTH_DEFAULT-1:0] RESET_VECTOR_DEFAULT = '1;

endpackage

// File: rtl/pc_stack_if.sv
// Execute-stage control bundle into the PC/return stack, plus its fetch
// address and status outputs.
interface pc_stack_if
  import pc_stack_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = PC_WIDTH_DEFAULT,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEFAULT
) ();

  fe_state_t                            fetchState;
  ex_state_t                            executeState;
  logic                                 goto;
  logic                                 call;
  logic                                 retlw;
  logic                                 pclWrite;
  logic [8:0]                           instK;
  logic [7:0]                           aluResult;
  logic [1:0]                           pageSel;
  logic [PC_WIDTH-1:0]                  pc;
  logic [7:0]                           pcl;
  logic [$clog2(STACK_DEPTH+1)-1:0]     stackDepth;
  logic                                 stackOverflow;

  modport master (
    output fetchState, executeState, goto, call, retlw, pclWrite,
           instK, aluResult, pageSel,
    input  pc, pcl, stackDepth, stackOverflow
  );

  modport slave (
    input  fetchState, executeState, goto, call, retlw, pclWrite,
           instK, aluResult, pageSel,
    output pc, pcl, stackDepth, stackOverflow
  );

endinterface

// File: rtl/pc_stack_return_stack.sv
// Fixed-depth hardware return stack: push shifts down dropping the oldest,
// pop shifts up keeping the bottom entry; saturating depth, sticky overflow.
module return_stack #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   push_data,
  output logic [WIDTH-1:0]   top,
  output logic [DEPTH_W-1:0] depth,
  output logic               overflow
);

  logic [WIDTH-1:0]   stack_q [DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic               overflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      depth_q    <= '0;
      overflow_q <= 1'b0;
    end else if (push) begin
      stack_q[0] <= push_data;
      for (int unsigned i = 1; i < DEPTH; i++) stack_q[i] <= stack_q[i-1];
      if (depth_q == DEPTH_W'(DEPTH)) overflow_q <= 1'b1;
      else                            depth_q    <= depth_q + DEPTH_W'(1);
    end else if (pop) begin
      // Bottom entry is not written, so an underflowing pop replays it.
      for (int unsigned i = 0; i + 1 < DEPTH; i++) stack_q[i] <= stack_q[i+1];
      if (depth_q != '0) depth_q <= depth_q - DEPTH_W'(1);
    end
  end

  assign top      = stack_q[0];
  assign depth    = depth_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/pc_stack.sv
// PIC16C5x program counter: FE_Q1 increment, EX_Q4 RETLW/CALL/GOTO/PCL loads
// with PA paging, backed by the return stack.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = PC_WIDTH_DEFAULT,
  parameter int unsigned         STACK_DEPTH  = STACK_DEPTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b1}}
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_stack_if.slave  bus
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] stack_top;
  logic [DEPTH_W-1:0]  depth;
  logic                overflow;
  logic                push;
  logic                pop;
  logic                fe_q1;
  logic                ex_q4;

  assign fe_q1 = (bus.fetchState == FE_Q1);
  assign ex_q4 = (bus.executeState == EX_Q4);

  // Loads take precedence over the increment should both phases coincide.
  always_comb begin
    pc_next = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (ex_q4 && bus.retlw) begin
      pc_next = stack_top;
      pop     = 1'b1;
    end else if (ex_q4 && bus.call) begin
      pc_next = PC_WIDTH'({bus.pageSel, 1'b0, bus.instK[7:0]});
      push    = 1'b1;
    end else if (ex_q4 && bus.goto) begin
      pc_next = PC_WIDTH'({bus.pageSel, bus.instK});
    end else if (ex_q4 && bus.pclWrite) begin
      pc_next = PC_WIDTH'({bus.pageSel, 1'b0, bus.aluResult});
    end else if (fe_q1) begin
      pc_next = pc_q + PC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_VECTOR;
    else        pc_q <= pc_next;
  end

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_q),
    .top       (stack_top),
    .depth     (depth),
    .overflow  (overflow)
  );

  assign bus.pc            = pc_q;
  assign bus.pcl           = 8'(pc_q);
  assign bus.stackDepth    = depth;
  assign bus.stackOverflow = overflow;

endmodule
